// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline stage register.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

    // Occupancy of the two-entry skid variant.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pstate_t;

    localparam int PIPE_W      = 32;
    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Latency: count updates on the same edge that samples inc/clr.
// Backpressure: none; holds at all-ones once saturated.
//
// Ports:
//   CLK, RST : clock, asynchronous active-high reset
//   inc      : add one this cycle (ignored once saturated)
//   clr      : force the count to zero
//   cnt      : current count
import pipe_pkg::*;

module sat_counter #(
    parameter int CNT_W = STALL_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush and a saturating stall counter.
// Latency: one cycle from accept to out_valid/out_data; one transfer per cycle sustained.
// Backpressure: SKID=1 absorbs one extra beat, in_ready registered; SKID=0 in_ready = !out_valid || out_ready.
//
// Ports:
//   CLK, RST              : clock, asynchronous active-high reset
//   flush                 : drop every held entry, out_data returns to RST_VAL
//   clr_cnt               : zero the stall counter
//   in_valid/in_ready/in_data    : upstream handshake and payload
//   out_valid/out_ready/out_data : downstream handshake and payload (always from the main register)
//   stall_cnt             : saturating count of cycles with out_valid && !out_ready
import pipe_pkg::*;

module pipe_stage_reg #(
    parameter int               WIDTH   = PIPE_W,
    parameter int               SKID    = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = STALL_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             clr_cnt,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    generate
        if (SKID != 0) begin : g_skid
            pstate_t          state_q, state_d;
            logic [WIDTH-1:0] main_q, main_d;
            logic [WIDTH-1:0] skid_q, skid_d;
            logic             rdy_q;
            logic             accept;
            logic             deliver;

            assign accept  = in_valid && rdy_q;
            assign deliver = (state_q != EMPTY) && out_ready;

            // State register; in_ready is registered from the next state so
            // out_ready never reaches in_ready combinationally.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    state_q <= EMPTY;
                    rdy_q   <= 1'b1;
                end else begin
                    state_q <= state_d;
                    rdy_q   <= (state_d != FULL);
                end
            end

            // Next-state logic; flush overrides everything.
            always_comb begin
                state_d = state_q;
                if (flush) begin
                    state_d = EMPTY;
                end else begin
                    case (state_q)
                        EMPTY: if (accept) state_d = BUSY;
                        BUSY: begin
                            if (accept && !deliver) begin
                                state_d = FULL;
                            end else if (!accept && deliver) begin
                                state_d = EMPTY;
                            end
                        end
                        FULL:    if (deliver) state_d = BUSY;
                        default: state_d = EMPTY;
                    endcase
                end
            end

            // Datapath steering. An accept during a flush is dropped; the
            // delivered beat was already sampled downstream from main_q.
            always_comb begin
                main_d = main_q;
                skid_d = skid_q;
                if (flush) begin
                    main_d = RST_VAL;
                end else begin
                    case (state_q)
                        EMPTY: if (accept) main_d = in_data;
                        BUSY: begin
                            if (accept && deliver) begin
                                main_d = in_data;
                            end else if (accept) begin
                                skid_d = in_data;
                            end
                        end
                        FULL:    if (deliver) main_d = skid_q;
                        default: main_d = main_q;
                    endcase
                end
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    main_q <= RST_VAL;
                    skid_q <= RST_VAL;
                end else begin
                    main_q <= main_d;
                    skid_q <= skid_d;
                end
            end

            assign in_ready  = rdy_q;
            assign out_valid = (state_q != EMPTY);
            assign out_data  = main_q;
        end else begin : g_bare
            logic             vld_q, vld_d;
            logic [WIDTH-1:0] main_q, main_d;
            logic             rdy;

            assign rdy = !vld_q || out_ready;

            always_comb begin
                vld_d  = vld_q;
                main_d = main_q;
                if (flush) begin
                    vld_d  = 1'b0;
                    main_d = RST_VAL;
                end else if (in_valid && rdy) begin
                    vld_d  = 1'b1;
                    main_d = in_data;
                end else if (vld_q && out_ready) begin
                    vld_d  = 1'b0;
                end
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    vld_q  <= 1'b0;
                    main_q <= RST_VAL;
                end else begin
                    vld_q  <= vld_d;
                    main_q <= main_d;
                end
            end

            assign in_ready  = rdy;
            assign out_valid = vld_q;
            assign out_data  = main_q;
        end
    endgenerate

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (out_valid && !out_ready),
        .clr (clr_cnt),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=0 (index 0) and SKID=1 (index 1) side by side
// on the same input stimulus, each with its own scoreboard queue and stall model.
module tb_pipe_stage_reg;

    localparam int          W   = 8;
    localparam int          CW  = 4;
    localparam int          SAT = (1 << CW) - 1;
    localparam logic [W-1:0] RV = 8'h5A;

    logic         CLK = 1'b0;
    logic         RST;
    logic         flush;
    logic         clr_cnt;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] in_data;

    logic          ov [2];
    logic          ir [2];
    logic [W-1:0]  od [2];
    logic [CW-1:0] sc [2];

    always #5 CLK = ~CLK;

    pipe_stage_reg #(.WIDTH(W), .SKID(0), .RST_VAL(RV), .CNT_W(CW)) dut_bare (
        .CLK(CLK), .RST(RST), .flush(flush), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .stall_cnt(sc[0])
    );

    pipe_stage_reg #(.WIDTH(W), .SKID(1), .RST_VAL(RV), .CNT_W(CW)) dut_skid (
        .CLK(CLK), .RST(RST), .flush(flush), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .stall_cnt(sc[1])
    );

    typedef logic [W-1:0] dq_t [$];
    dq_t          sbq      [2];
    logic [W-1:0] exp_data [2];
    int           exp_sc   [2];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            sbq[k].delete();
            exp_data[k] = RV;
            exp_sc[k]   = 0;
        end
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy,
                         input logic fl, input logic cl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        clr_cnt   = cl;
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle();
        logic exp_rdy, acc, del;
        int   occ;
        #1;
        for (int k = 0; k < 2; k++) begin
            occ     = sbq[k].size();
            exp_rdy = (k == 1) ? (occ < 2) : ((occ == 0) || out_ready);
            chk($sformatf("in_ready[%0d]", k), 32'(ir[k]), 32'(exp_rdy));
            acc = in_valid && exp_rdy;
            del = (occ > 0) && out_ready;
            if (!RST) begin
                if (del) chk($sformatf("deliver[%0d]", k), 32'(od[k]), 32'(sbq[k][0]));
                if (clr_cnt) exp_sc[k] = 0;
                else if ((occ > 0) && !out_ready && (exp_sc[k] < SAT)) exp_sc[k]++;
                if (flush) begin
                    sbq[k].delete();
                    exp_data[k] = RV;
                end else begin
                    if (del) void'(sbq[k].pop_front());
                    if (acc) sbq[k].push_back(in_data);
                    if (sbq[k].size() > 0) exp_data[k] = sbq[k][0];
                end
            end
        end
        @(posedge CLK);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("out_valid[%0d]", k), 32'(ov[k]), 32'(sbq[k].size() > 0));
            chk($sformatf("out_data[%0d]", k),  32'(od[k]), 32'(exp_data[k]));
            chk($sformatf("stall_cnt[%0d]", k), 32'(sc[k]), 32'(exp_sc[k]));
        end
        @(negedge CLK);
    endtask

    int seq;

    initial begin
        RST = 1'b1;
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        model_reset();
        @(negedge CLK);
        repeat (3) cycle();
        RST = 1'b0;

        // Back-to-back stream with a ready sink.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (2) cycle();

        // Backpressure fill: SKID=1 reaches FULL after two pushes.
        drive(1'b1, 8'h0A, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 8'h0B, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("full_in_ready", 32'(ir[1]), 32'(0));
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle();

        // Flush together with accept and deliver while FULL.
        drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 8'h0C, 1'b1, 1'b1, 1'b0);
        cycle();
        chk("flush_out_valid", 32'(ov[1]), 32'(0));
        chk("flush_out_data",  32'(od[1]), 32'(RV));
        chk("flush_in_ready",  32'(ir[1]), 32'(1));
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (2) cycle();

        // Asynchronous reset between edges while FULL and stalling.
        drive(1'b1, 8'h21, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) cycle();
        #2 RST = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("arst_out_valid[%0d]", k), 32'(ov[k]), 32'(0));
            chk($sformatf("arst_stall_cnt[%0d]", k), 32'(sc[k]), 32'(0));
            chk($sformatf("arst_out_data[%0d]", k),  32'(od[k]), 32'(RV));
        end
        model_reset();
        @(negedge CLK);
        cycle();
        RST = 1'b0;

        // Counter saturation and clear-beats-increment.
        drive(1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (20) cycle();
        chk("sat_skid", 32'(sc[1]), 32'(SAT));
        chk("sat_bare", 32'(sc[0]), 32'(SAT));
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle();
        chk("clr_skid", 32'(sc[1]), 32'(0));
        chk("clr_bare", 32'(sc[0]), 32'(0));
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle();

        // Random traffic shared by both variants.
        seq = 8'h40;
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 3) != 0), 8'(seq), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 24) == 0), ($urandom_range(0, 39) == 0));
            seq++;
            cycle();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It replaces hand-written per-stage latch/enable/clear logic between IF/ID/EX/MEM/WB, so every stage boundary supports backpressure, bubble insertion and hazard flushes. It also provides a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- WIDTH, 32: payload width in bits; the caller packs control and data fields into it.
- SKID, 1: 1 selects a two-entry skid buffer with registered in_ready; 0 selects a single register with combinational in_ready.
- RST_VAL, '0: value of out_data after reset or flush.
- CNT_W, 16: width of the stall counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous flush: kills all held entries.
- clr_cnt  input  1  synchronous clear of stall_cnt.
- in_valid  input  1  upstream has a payload.
- in_ready  output  1  stage can accept a payload.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  downstream payload is valid.
- out_ready  input  1  downstream accepts the payload.
- out_data  output  WIDTH  downstream payload.
- stall_cnt  output  CNT_W  saturating count of cycles with out_valid && !out_ready.

## Operation
- Accept: in_valid && in_ready on a rising edge. Deliver: out_valid && out_ready on a rising edge.
- out_data is driven only from the main register, never combinationally from in_data.
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational).
  - An accept loads the main register.
  - A deliver with no accept clears out_valid.
- SKID=1 has three states:
  - EMPTY: accept moves to BUSY (main loaded).
  - BUSY:
    - Accept without deliver loads the skid register and moves to FULL.
    - Accept with deliver loads main and stays in BUSY.
    - Deliver without accept moves to EMPTY.
  - FULL:
    - in_ready=0.
    - Deliver copies skid into main and moves to BUSY.
- in_ready (SKID=1) is a register, equal to (next state != FULL).
- Flush has priority over every other event in the same cycle:
  - All entries are invalidated, out_data is set to RST_VAL and the state goes to EMPTY.
  - An accept in the flush cycle is consumed and dropped.
  - A deliver in the flush cycle is still a valid transfer; downstream sees the payload it sampled.
- Payload is never reordered, duplicated or lost except by flush.
- stall_cnt:
  - Increments by 1 on each cycle with out_valid && !out_ready.
  - Saturates at 2^CNT_W-1.
  - clr_cnt forces it to 0 and wins over an increment in the same cycle.
  - flush does not affect it.

## Timing
- Reset values: out_valid=0, out_data=RST_VAL, stall_cnt=0, state EMPTY.
- in_ready after reset: 1 when SKID=1; equal to the combinational expression when SKID=0, which gives 1.
- RST takes effect immediately and asynchronously, including mid-transfer and in FULL; release is synchronous to CLK as supplied by the reset synchroniser.
- Latency: an accepted payload appears on out_data/out_valid on the next edge in both modes.
- Throughput: one transfer per cycle sustained in both modes.
- SKID=1: there is no combinational path from out_ready to in_ready.
- Handshake rules:
  - Once out_valid=1, out_data stays stable until delivered or flushed.
  - in_valid may drop without an accept.
- Flush latency: out_valid=0 on the edge after flush is sampled.
- stall_cnt is updated on the same edge as the sampled stall.

## Structure
- Package pipe_pkg:
  - pstate_t enum {EMPTY, BUSY, FULL}.
  - Parameter defaults PIPE_W=32 and STALL_CNT_W=16.
- One sub-module is natural: sat_counter, with parameter CNT_W and inputs inc and clr, instantiated for stall_cnt.
- The SKID=0 and SKID=1 datapaths are built in a generate branch.

## Test plan
- Reset then stream:
  - Stimulus: RST high 3 cycles, then in_data = 1,2,3,4 on consecutive cycles, out_ready=1.
  - Response: out_data = 1,2,3,4 one cycle later, with no gaps; in_ready stays 1; stall_cnt=0.
- Backpressure fill (SKID=1):
  - Stimulus: out_ready=0, push 0xA then 0xB.
  - Response: state FULL and in_ready=0 after the second edge.
  - Then raise out_ready: delivers 0xA then 0xB in order; stall_cnt equals the number of held cycles.
- Simultaneous flush, accept and deliver:
  - Stimulus: in FULL, assert flush together with in_valid (0xC) and out_ready.
  - Response: next cycle out_valid=0, out_data=RST_VAL, in_ready=1; 0xC never appears.
- Asynchronous reset mid-stall:
  - Stimulus: assert RST between edges while FULL.
  - Response: out_valid=0 and stall_cnt=0 immediately, without waiting for a clock edge.
- Counter saturation:
  - Stimulus: CNT_W=4, 20 stall cycles.
  - Response: stall_cnt=15.
  - clr_cnt asserted in the same cycle as a stall gives stall_cnt=0.
- SKID=0 equivalence:
  - Stimulus: the same random valid/ready traffic as the SKID=1 runs.
  - Response: identical output data order; in_ready == !out_valid || out_ready every cycle.
